ff7_wb_stage: RTL and testbench
===============================

// Module: ff7_wb_stage
// PURPOSE
//  Stage FF7 and register-file writeback for the dual-issue SPU datapath; consumes the even/odd result bundle from FF6.
//  Holds up to 2 paired bundles in a FIFO so FF6 can be back-pressured while the register file is busy.
//  Resolves same-address even/odd write conflicts and keeps per-pipe saturating retire counters.
// PARAMETERS
//  RT_W     128  result width per pipe
//  ADDR_W   7    register address width
//  UID_W    3    unit id width
//  MADDR_W  32   memory address width
//  CNT_W    32   retire/conflict counter width
// PORTS
//  clk           in   1        clock
//  rst           in   1        reset: synchronous, active-high
//  flush         in   1        discard all buffered bundles
//  in_valid      in   1        FF6 bundle valid
//  in_ready      out  1        stage can accept a bundle
//  in_rtaddr_e   in   ADDR_W   even-pipe destination
//  in_wreg_e     in   1        even-pipe write enable
//  in_rt_e       in   RT_W     even-pipe result
//  in_uid_e      in   UID_W    even-pipe unit id
//  in_rtaddr_o   in   ADDR_W   odd-pipe destination
//  in_wreg_o     in   1        odd-pipe write enable
//  in_rt_o       in   RT_W     odd-pipe result
//  in_uid_o      in   UID_W    odd-pipe unit id
//  in_maddr      in   MADDR_W  odd-pipe memory address
//  rf_ready      in   1        register file accepts writes this cycle
//  rf_we_e       out  1        even write strobe
//  rf_waddr_e    out  ADDR_W   even write address
//  rf_wdata_e    out  RT_W     even write data
//  rf_we_o       out  1        odd write strobe
//  rf_waddr_o    out  ADDR_W   odd write address
//  rf_wdata_o    out  RT_W     odd write data
//  wb_uid_e      out  UID_W    uid of even write
//  wb_uid_o      out  UID_W    uid of odd write
//  wb_maddr      out  MADDR_W  memory address of last drained bundle
//  retire_cnt_e  out  CNT_W    even writes committed
//  retire_cnt_o  out  CNT_W    odd writes committed
//  conflict_cnt  out  CNT_W    same-address conflicts resolved
// BEHAVIOUR
//  - Reset: FIFO empty, every output 0, except in_ready=1.
//  - in_ready = (count<2); registered from count, not combinational on rf_ready.
//  - Push when in_valid&&in_ready. Bundles with wreg_e=wreg_o=0 are still pushed; they drain with no strobes.
//  - FIFO: 2 entries, head/tail 1-bit pointers wrap 1->0. count in {0,1,2}.
//  - Drain: registered outputs. When the head is valid && rf_ready at edge N, the strobes are asserted for the cycle after edge N (1 cycle, then deasserted unless another drain).
//  - Strobe values: rf_we_x = head.wreg_x; addr/data/uid come from the head; wb_maddr <= head.maddr.
//  - Min latency: accept at edge N (count 0) -> strobes visible after edge N+1.
//  - Conflict: head.wreg_e && head.wreg_o && addr_e==addr_o -> the odd pipe is younger and wins.
//    rf_we_e=0, rf_we_o=1, conflict_cnt+1.
//  - Push and drain in the same edge: count unchanged (legal at count 1; at count 2 no push occurs).
//  - rf_ready=0: no drain, strobes 0, FIFO holds; fills to 2, then in_ready=0.
//  - flush (priority over push/drain): FIFO emptied, strobes 0 next cycle, and in_ready=1 next cycle.
//    Counters and wb_maddr keep their values.
//  - Counters: +1 per asserted strobe of that pipe; saturate at all-ones, no wrap.
//  - rst mid-operation: same as reset; buffered bundles are lost and no strobe follows.
// TESTING
//  1 rst, then 1 bundle (e: addr5/data A, o: addr9/data B), rf_ready=1 -> next-next cycle we_e=we_o=1, addrs 5/9; retire_cnt_e=retire_cnt_o=1.
//  2 Both pipes addr 12 -> only we_o=1 with data_o; conflict_cnt=1; retire_cnt_e unchanged.
//  3 rf_ready=0, 3 back-to-back bundles -> 2 accepted, in_ready=0 on the 3rd.
//    rf_ready=1 -> 2 drains in order, then in_ready=1.
//  4 count=2 plus flush -> no strobes; count 0; in_ready=1 next cycle; counters unchanged.
//  5 Preload retire_cnt_o=all-ones via force; drain an odd write -> stays all-ones.
//  6 Continuous stream with rf_ready toggling 1/0 each cycle -> no loss or reorder (scoreboard); wb_maddr tracks the drained bundle.

Source files
------------

// File: rtl/ff7_wb_stage.sv
// FF7 writeback stage: 2-deep bundle FIFO in front of the dual-port register file,
// resolving same-address even/odd writes and counting retired writes per pipe.
module ff7_wb_stage #(
  parameter int RT_W    = 128,
  parameter int ADDR_W  = 7,
  parameter int UID_W   = 3,
  parameter int MADDR_W = 32,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ADDR_W-1:0]  in_rtaddr_e,
  input  logic               in_wreg_e,
  input  logic [RT_W-1:0]    in_rt_e,
  input  logic [UID_W-1:0]   in_uid_e,
  input  logic [ADDR_W-1:0]  in_rtaddr_o,
  input  logic               in_wreg_o,
  input  logic [RT_W-1:0]    in_rt_o,
  input  logic [UID_W-1:0]   in_uid_o,
  input  logic [MADDR_W-1:0] in_maddr,
  input  logic               rf_ready,
  output logic               rf_we_e,
  output logic [ADDR_W-1:0]  rf_waddr_e,
  output logic [RT_W-1:0]    rf_wdata_e,
  output logic               rf_we_o,
  output logic [ADDR_W-1:0]  rf_waddr_o,
  output logic [RT_W-1:0]    rf_wdata_o,
  output logic [UID_W-1:0]   wb_uid_e,
  output logic [UID_W-1:0]   wb_uid_o,
  output logic [MADDR_W-1:0] wb_maddr,
  output logic [CNT_W-1:0]   retire_cnt_e,
  output logic [CNT_W-1:0]   retire_cnt_o,
  output logic [CNT_W-1:0]   conflict_cnt
);

  typedef struct packed {
    logic               wreg_e;
    logic [ADDR_W-1:0]  addr_e;
    logic [RT_W-1:0]    rt_e;
    logic [UID_W-1:0]   uid_e;
    logic               wreg_o;
    logic [ADDR_W-1:0]  addr_o;
    logic [RT_W-1:0]    rt_o;
    logic [UID_W-1:0]   uid_o;
    logic [MADDR_W-1:0] maddr;
  } bundle_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  bundle_t              mem_q [2];
  bundle_t              mem_d [2];
  bundle_t              head;
  logic [1:0]           count_q, count_d;
  logic                 head_q, head_d, tail_q, tail_d;
  logic                 in_ready_q, in_ready_d;
  logic                 we_e_q, we_e_d, we_o_q, we_o_d;
  logic [ADDR_W-1:0]    waddr_e_q, waddr_e_d, waddr_o_q, waddr_o_d;
  logic [RT_W-1:0]      wdata_e_q, wdata_e_d, wdata_o_q, wdata_o_d;
  logic [UID_W-1:0]     uid_e_q, uid_e_d, uid_o_q, uid_o_d;
  logic [MADDR_W-1:0]   maddr_q, maddr_d;
  logic [CNT_W-1:0]     retire_cnt_e_q, retire_cnt_e_d;
  logic [CNT_W-1:0]     retire_cnt_o_q, retire_cnt_o_d;
  logic [CNT_W-1:0]     conflict_cnt_q, conflict_cnt_d;
  logic                 push, drain, conflict;

  always_comb begin
    head     = mem_q[head_q];
    // Odd pipe is the younger instruction, so it owns a shared destination.
    conflict = head.wreg_e && head.wreg_o && (head.addr_e == head.addr_o);
    push     = in_valid && in_ready_q && !flush;
    drain    = (count_q != 2'd0) && rf_ready && !flush;

    mem_d = mem_q;
    if (push) begin
      mem_d[tail_q] = '{wreg_e: in_wreg_e, addr_e: in_rtaddr_e, rt_e: in_rt_e, uid_e: in_uid_e,
                        wreg_o: in_wreg_o, addr_o: in_rtaddr_o, rt_o: in_rt_o, uid_o: in_uid_o,
                        maddr: in_maddr};
    end

    count_d = count_q;
    if (push && !drain)      count_d = count_q + 2'd1;
    else if (drain && !push) count_d = count_q - 2'd1;
    head_d = drain ? ~head_q : head_q;
    tail_d = push  ? ~tail_q : tail_q;
    if (flush) begin
      count_d = 2'd0;
      head_d  = 1'b0;
      tail_d  = 1'b0;
    end
    in_ready_d = (count_d != 2'd2);

    we_e_d    = drain && head.wreg_e && !conflict;
    we_o_d    = drain && head.wreg_o;
    waddr_e_d = drain ? head.addr_e : waddr_e_q;
    wdata_e_d = drain ? head.rt_e   : wdata_e_q;
    uid_e_d   = drain ? head.uid_e  : uid_e_q;
    waddr_o_d = drain ? head.addr_o : waddr_o_q;
    wdata_o_d = drain ? head.rt_o   : wdata_o_q;
    uid_o_d   = drain ? head.uid_o  : uid_o_q;
    maddr_d   = drain ? head.maddr  : maddr_q;

    retire_cnt_e_d = sat_inc(retire_cnt_e_q, we_e_d);
    retire_cnt_o_d = sat_inc(retire_cnt_o_q, we_o_d);
    conflict_cnt_d = sat_inc(conflict_cnt_q, drain && conflict);
  end

  // FIFO storage carries no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q        <= 2'd0;
      head_q         <= 1'b0;
      tail_q         <= 1'b0;
      in_ready_q     <= 1'b1;
      we_e_q         <= 1'b0;
      we_o_q         <= 1'b0;
      waddr_e_q      <= '0;
      wdata_e_q      <= '0;
      uid_e_q        <= '0;
      waddr_o_q      <= '0;
      wdata_o_q      <= '0;
      uid_o_q        <= '0;
      maddr_q        <= '0;
      retire_cnt_e_q <= '0;
      retire_cnt_o_q <= '0;
      conflict_cnt_q <= '0;
    end else begin
      count_q        <= count_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      in_ready_q     <= in_ready_d;
      we_e_q         <= we_e_d;
      we_o_q         <= we_o_d;
      waddr_e_q      <= waddr_e_d;
      wdata_e_q      <= wdata_e_d;
      uid_e_q        <= uid_e_d;
      waddr_o_q      <= waddr_o_d;
      wdata_o_q      <= wdata_o_d;
      uid_o_q        <= uid_o_d;
      maddr_q        <= maddr_d;
      retire_cnt_e_q <= retire_cnt_e_d;
      retire_cnt_o_q <= retire_cnt_o_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign rf_we_e      = we_e_q;
  assign rf_waddr_e   = waddr_e_q;
  assign rf_wdata_e   = wdata_e_q;
  assign rf_we_o      = we_o_q;
  assign rf_waddr_o   = waddr_o_q;
  assign rf_wdata_o   = wdata_o_q;
  assign wb_uid_e     = uid_e_q;
  assign wb_uid_o     = uid_o_q;
  assign wb_maddr     = maddr_q;
  assign retire_cnt_e = retire_cnt_e_q;
  assign retire_cnt_o = retire_cnt_o_q;
  assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_ff7_wb_stage.sv
// Scoreboard bench for ff7_wb_stage: directed bundles are queued with their expected
// register-file writes, and a negedge monitor checks every strobe against the queue.
module tb_ff7_wb_stage;

  logic         clk = 1'b0;
  logic         rst, flush, in_valid, in_ready, rf_ready;
  logic [6:0]   in_rtaddr_e, in_rtaddr_o, rf_waddr_e, rf_waddr_o;
  logic         in_wreg_e, in_wreg_o, rf_we_e, rf_we_o;
  logic [127:0] in_rt_e, in_rt_o, rf_wdata_e, rf_wdata_o;
  logic [2:0]   in_uid_e, in_uid_o, wb_uid_e, wb_uid_o;
  logic [31:0]  in_maddr, wb_maddr, retire_cnt_e, retire_cnt_o, conflict_cnt;

  always #5 clk = ~clk;

  ff7_wb_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_rtaddr_e(in_rtaddr_e), .in_wreg_e(in_wreg_e), .in_rt_e(in_rt_e), .in_uid_e(in_uid_e),
    .in_rtaddr_o(in_rtaddr_o), .in_wreg_o(in_wreg_o), .in_rt_o(in_rt_o), .in_uid_o(in_uid_o),
    .in_maddr(in_maddr), .rf_ready(rf_ready),
    .rf_we_e(rf_we_e), .rf_waddr_e(rf_waddr_e), .rf_wdata_e(rf_wdata_e),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .wb_uid_e(wb_uid_e), .wb_uid_o(wb_uid_o), .wb_maddr(wb_maddr),
    .retire_cnt_e(retire_cnt_e), .retire_cnt_o(retire_cnt_o), .conflict_cnt(conflict_cnt)
  );

  typedef struct {
    logic         we_e;
    logic [6:0]   addr_e;
    logic [127:0] data_e;
    logic [2:0]   uid_e;
    logic         we_o;
    logic [6:0]   addr_o;
    logic [127:0] data_o;
    logic [2:0]   uid_o;
    logic [31:0]  maddr;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  int   strobes_seen = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe cycle must match the oldest outstanding bundle.
  always @(negedge clk) begin
    if (!rst && (rf_we_e || rf_we_o)) begin
      strobes_seen++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got we_e=%0b we_o=%0b expected none", rf_we_e, rf_we_o);
      end else begin
        cur = sb.pop_front();
        chk("we_e", rf_we_e, cur.we_e);
        chk("we_o", rf_we_o, cur.we_o);
        if (cur.we_e) begin
          chk("waddr_e", rf_waddr_e, cur.addr_e);
          chk("wdata_e", rf_wdata_e, cur.data_e);
          chk("uid_e", wb_uid_e, cur.uid_e);
        end
        if (cur.we_o) begin
          chk("waddr_o", rf_waddr_o, cur.addr_o);
          chk("wdata_o", rf_wdata_o, cur.data_o);
          chk("uid_o", wb_uid_o, cur.uid_o);
        end
        chk("wb_maddr", wb_maddr, cur.maddr);
      end
    end
  end

  // Called at a negedge; returns at the following negedge after the bundle was offered.
  task automatic send(input logic wre, input logic [6:0] ae, input logic [127:0] de, input logic [2:0] ue,
                      input logic wro, input logic [6:0] ao, input logic [127:0] dov, input logic [2:0] uo,
                      input logic [31:0] ma, input bit track);
    exp_t x;
    int   n = 0;
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 60 cycles");
      return;
    end
    in_valid = 1'b1;
    in_wreg_e = wre; in_rtaddr_e = ae; in_rt_e = de; in_uid_e = ue;
    in_wreg_o = wro; in_rtaddr_o = ao; in_rt_o = dov; in_uid_o = uo;
    in_maddr = ma;
    if (track) begin
      x.we_e = wre && !(wre && wro && (ae == ao));
      x.addr_e = ae; x.data_e = de; x.uid_e = ue;
      x.we_o = wro; x.addr_o = ao; x.data_o = dov; x.uid_o = uo;
      x.maddr = ma;
      sb.push_back(x);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk(name, 128'(sb.size()), 128'd0);
  endtask

  logic [31:0] sv_e, sv_o, sv_c;
  int          seen0;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; rf_ready = 1'b0;
    in_wreg_e = 1'b0; in_rtaddr_e = '0; in_rt_e = '0; in_uid_e = '0;
    in_wreg_o = 1'b0; in_rtaddr_o = '0; in_rt_o = '0; in_uid_o = '0; in_maddr = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_we_e", rf_we_e, 1'b0);
    chk("rst_we_o", rf_we_o, 1'b0);
    chk("rst_wdata_o", rf_wdata_o, 128'd0);
    chk("rst_maddr", wb_maddr, 32'd0);
    chk("rst_retire_e", retire_cnt_e, 32'd0);
    chk("rst_conflict", conflict_cnt, 32'd0);

    // 1: single bundle, distinct destinations
    rf_ready = 1'b1;
    send(1'b1, 7'd5, 128'hAAAA_0001, 3'd1, 1'b1, 7'd9, 128'hBBBB_0002, 3'd2, 32'h0000_0100, 1'b1);
    repeat (3) @(negedge clk);
    chk("t1_retire_e", retire_cnt_e, 32'd1);
    chk("t1_retire_o", retire_cnt_o, 32'd1);
    chk("t1_sb_empty", 128'(sb.size()), 128'd0);

    // 2: same destination on both pipes, odd wins
    send(1'b1, 7'd12, 128'hCCCC_0003, 3'd3, 1'b1, 7'd12, 128'hDDDD_0004, 3'd4, 32'h0000_0200, 1'b1);
    repeat (3) @(negedge clk);
    chk("t2_conflict", conflict_cnt, 32'd1);
    chk("t2_retire_e", retire_cnt_e, 32'd1);
    chk("t2_retire_o", retire_cnt_o, 32'd2);

    // 3: back-pressure fills the FIFO, third bundle refused
    rf_ready = 1'b0;
    send(1'b1, 7'd20, 128'h1111, 3'd5, 1'b0, 7'd21, 128'h2222, 3'd6, 32'h0000_0300, 1'b1);
    send(1'b0, 7'd22, 128'h3333, 3'd7, 1'b1, 7'd23, 128'h4444, 3'd0, 32'h0000_0304, 1'b1);
    chk("t3_full_ready", in_ready, 1'b0);
    in_valid = 1'b1; in_wreg_e = 1'b1; in_rtaddr_e = 7'd30; in_rt_e = 128'h5555; in_maddr = 32'h0000_0308;
    repeat (2) @(negedge clk);
    chk("t3_still_full", in_ready, 1'b0);
    in_valid = 1'b0;
    rf_ready = 1'b1;
    wait_empty("t3_drained");
    chk("t3_ready_again", in_ready, 1'b1);
    chk("t3_retire_e", retire_cnt_e, 32'd2);
    chk("t3_retire_o", retire_cnt_o, 32'd3);

    // 4: flush a full FIFO while the register file is ready
    rf_ready = 1'b0;
    send(1'b1, 7'd40, 128'h6666, 3'd1, 1'b1, 7'd41, 128'h7777, 3'd2, 32'h0000_0400, 1'b0);
    send(1'b1, 7'd42, 128'h8888, 3'd3, 1'b1, 7'd43, 128'h9999, 3'd4, 32'h0000_0404, 1'b0);
    chk("t4_full", in_ready, 1'b0);
    sv_e = retire_cnt_e; sv_o = retire_cnt_o; sv_c = conflict_cnt;
    seen0 = strobes_seen;
    flush = 1'b1; rf_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("t4_ready_next", in_ready, 1'b1);
    chk("t4_we_e", rf_we_e, 1'b0);
    chk("t4_we_o", rf_we_o, 1'b0);
    repeat (4) @(negedge clk);
    chk("t4_no_strobes", 128'(strobes_seen - seen0), 128'd0);
    chk("t4_retire_e", retire_cnt_e, sv_e);
    chk("t4_retire_o", retire_cnt_o, sv_o);
    chk("t4_conflict", conflict_cnt, sv_c);
    chk("t4_maddr_kept", wb_maddr, 32'h0000_0304);

    // 5: odd counter saturates
    force dut.retire_cnt_o_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt_o_q;
    @(negedge clk);
    chk("t5_preload", retire_cnt_o, 32'hFFFF_FFFF);
    send(1'b0, 7'd2, 128'h0, 3'd0, 1'b1, 7'd3, 128'hEEEE_0005, 3'd5, 32'h0000_0500, 1'b1);
    repeat (3) @(negedge clk);
    chk("t5_saturated", retire_cnt_o, 32'hFFFF_FFFF);
    chk("t5_retire_e", retire_cnt_e, sv_e);

    // 6: stream under toggling rf_ready
    fork
      begin
        repeat (40) begin
          @(negedge clk);
          rf_ready = ~rf_ready;
        end
        rf_ready = 1'b1;
      end
      begin
        for (int i = 0; i < 8; i++) begin
          send(1'b1, 7'(i), {$urandom, $urandom, $urandom, $urandom}, 3'(i),
               (i % 3) != 0, 7'(i + 16), {$urandom, $urandom, $urandom, $urandom}, 3'(7 - i),
               32'h0000_1000 + 32'(i * 4), 1'b1);
        end
      end
    join
    wait_empty("t6_drained");
    chk("t6_last_maddr", wb_maddr, 32'h0000_101C);

    // 7: reset mid-operation drops buffered bundles
    rf_ready = 1'b0;
    send(1'b1, 7'd50, 128'hF00D, 3'd1, 1'b1, 7'd51, 128'hBEEF, 3'd2, 32'h0000_0600, 1'b0);
    seen0 = strobes_seen;
    rst = 1'b1; rf_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("t7_no_strobes", 128'(strobes_seen - seen0), 128'd0);
    chk("t7_retire_o", retire_cnt_o, 32'd0);
    chk("t7_maddr", wb_maddr, 32'd0);
    chk("t7_ready", in_ready, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
